// File: rtl/axil_arb_pkg.sv
// Shared types for the two-port AXI4-Lite master arbiter: FSM states,
// requester index type and requester count.
package axil_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } arb_state_e;

endpackage

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the port that did not win last time. Output is one-hot or zero.
module axil_rr_arb2
    import axil_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last_grant,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI4-Lite master port between two requesters, one transaction at
// a time. Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
//
// Handshakes: every AXI channel transfers on a cycle where valid && ready are
// both high; a valid, once raised, is held with stable payload until that
// cycle. Requesters hold rq_valid until rq_ready pulses (the transfer cycle);
// rs_valid is a one-cycle completion pulse with no back-pressure.
module axil_master_arbiter
    import axil_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        rq_valid,
    output logic [NUM_REQ-1:0]        rq_ready,
    input  logic [NUM_REQ-1:0]        rq_write,
    input  logic [AXI_ADDR_WIDTH-1:0] rq_addr0,
    input  logic [AXI_ADDR_WIDTH-1:0] rq_addr1,
    input  logic [AXI_DATA_WIDTH-1:0] rq_wdata0,
    input  logic [AXI_DATA_WIDTH-1:0] rq_wdata1,
    output logic [NUM_REQ-1:0]        rs_valid,
    output logic [AXI_DATA_WIDTH-1:0] rs_rdata,
    output logic                      rs_err,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DATA_WIDTH-1:0] m_wdata,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output arb_state_e                dbg_state
);

    arb_state_e                state_q, state_n, state_d;
    req_idx_t                  grant_q, last_grant_q, win_idx;
    logic [NUM_REQ-1:0]        gnt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                      aw_done_q, w_done_q;
    logic                      aw_hs, w_hs, ar_hs, rd_capture, timeout_fire;

    axil_rr_arb2 u_rr (
        .req        (rq_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign win_idx   = gnt[1];
    assign rq_ready  = (state_q == IDLE) ? gnt : '0;
    assign rs_valid  = (state_q == DONE) ? (2'b01 << grant_q) : '0;
    assign rs_rdata  = rdata_q;
    assign dbg_state = state_q;

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_awvalid = (state_q == WADDR) && !aw_done_q;
    assign m_wvalid  = (state_q == WADDR) && !w_done_q;
    assign m_bready  = (state_q == WRESP);
    assign m_arvalid = (state_q == RADDR);
    // Held through RDATA too, so a one-cycle rvalid is never dropped.
    assign m_rready  = (state_q == RADDR) || (state_q == RDATA);

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign ar_hs = m_arvalid && m_arready;
    assign rd_capture = ((state_q == RADDR) && ar_hs && m_rvalid) ||
                        ((state_q == RDATA) && m_rvalid);

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (|gnt) state_n = rq_write[win_idx] ? WADDR : RADDR;
            WADDR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_n = WRESP;
            WRESP:   if (m_bvalid) state_n = DONE;
            RADDR:   if (ar_hs) state_n = m_rvalid ? DONE : RDATA;
            RDATA:   if (m_rvalid) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        state_d = timeout_fire ? DONE : state_n;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && (|gnt)) begin
                grant_q      <= win_idx;
                last_grant_q <= win_idx;
                addr_q       <= (win_idx == 1'b1) ? rq_addr1 : rq_addr0;
                wdata_q      <= (win_idx == 1'b1) ? rq_wdata1 : rq_wdata0;
                aw_done_q    <= 1'b0;
                w_done_q     <= 1'b0;
            end
            if (state_q == WADDR) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (rd_capture) rdata_q <= m_rdata;
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;

    // A genuine response arriving on the limit cycle takes precedence.
    assign timeout_fire = (state_q inside {WADDR, WRESP, RADDR, RDATA}) &&
                          (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                          (state_n != DONE);
    assign rs_err = err_q;

    always_ff @(posedge aclk) begin
        if (areset || (state_q == IDLE)) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_q <= 1'b0;
        end else if (timeout_fire) begin
            err_q <= 1'b1;
        end else if ((state_n == DONE) && (state_q != DONE)) begin
            err_q <= 1'b0;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign rs_err       = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a small AXI-Lite register slave
// (registers 1..8, register n at byte address 4*(n-1)).
module tb_axil_master_arbiter;
    import axil_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [1:0]    rq_valid = '0, rq_ready, rq_write = '0, rs_valid;
    logic [AW-1:0] rq_addr0 = '0, rq_addr1 = '0, m_awaddr, m_araddr;
    logic [DW-1:0] rq_wdata0 = '0, rq_wdata1 = '0, rs_rdata, m_wdata, m_rdata;
    logic          rs_err, m_awvalid, m_awready, m_wvalid, m_wready;
    logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    arb_state_e    dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axil_master_arbiter #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk (aclk), .areset (areset),
        .rq_valid (rq_valid), .rq_ready (rq_ready), .rq_write (rq_write),
        .rq_addr0 (rq_addr0), .rq_addr1 (rq_addr1),
        .rq_wdata0 (rq_wdata0), .rq_wdata1 (rq_wdata1),
        .rs_valid (rs_valid), .rs_rdata (rs_rdata), .rs_err (rs_err),
        .m_awaddr (m_awaddr), .m_awvalid (m_awvalid), .m_awready (m_awready),
        .m_wdata (m_wdata), .m_wvalid (m_wvalid), .m_wready (m_wready),
        .m_bvalid (m_bvalid), .m_bready (m_bready),
        .m_araddr (m_araddr), .m_arvalid (m_arvalid), .m_arready (m_arready),
        .m_rdata (m_rdata), .m_rvalid (m_rvalid), .m_rready (m_rready),
        .dbg_state (dbg_state)
    );

    // ---------------- slave model ----------------
    logic [DW-1:0] slave_regs [1:8];
    int            aw_delay = 0;
    bit            r_never = 1'b0;
    int            aw_cnt;
    logic [AW-1:0] s_awaddr;
    logic [DW-1:0] s_wdata;
    logic          got_aw, got_w;
    int            cyc = 0;
    int            aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    int            aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0;
    int            rs0_n = 0, rs1_n = 0, aw_only_n = 0, multi_rdy_n = 0;

    assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid;
    assign m_arready = m_arvalid;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        if (areset) begin
            got_aw <= 1'b0; got_w <= 1'b0; m_bvalid <= 1'b0;
            m_rvalid <= 1'b0; m_rdata <= '0; aw_cnt <= 0;
        end else begin
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            if (m_awvalid && m_awready) begin s_awaddr <= m_awaddr; got_aw <= 1'b1; end
            if (m_wvalid && m_wready) begin s_wdata <= m_wdata; got_w <= 1'b1; end
            if (got_aw && got_w && !m_bvalid) begin
                slave_regs[int'(s_awaddr[4:2]) + 1] <= s_wdata;
                m_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= !r_never;
                m_rdata  <= slave_regs[int'(m_araddr[4:2]) + 1];
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    always @(posedge aclk) begin
        if (!areset) begin
            if (m_awvalid && m_awready) begin aw_hs_n <= aw_hs_n + 1; aw_hs_cyc <= cyc; end
            if (m_wvalid && m_wready)   begin w_hs_n <= w_hs_n + 1;   w_hs_cyc <= cyc;  end
            if (m_bvalid && m_bready)   begin b_hs_n <= b_hs_n + 1;   b_hs_cyc <= cyc;  end
        end
    end

    always @(negedge aclk) begin
        if (rs_valid[0]) rs0_n <= rs0_n + 1;
        if (rs_valid[1]) rs1_n <= rs1_n + 1;
        if (m_awvalid && !m_wvalid) aw_only_n <= aw_only_n + 1;
        if (rq_ready == 2'b11) multi_rdy_n <= multi_rdy_n + 1;
    end

    // ---------------- driver ----------------
    task automatic do_request(input int port, input bit wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, output bit granted, output bit done,
                              output logic [DW-1:0] rdata, output logic err,
                              output int g_cyc, output int r_cyc);
        granted = 1'b0; done = 1'b0; rdata = '0; err = 1'b0; g_cyc = 0; r_cyc = 0;
        @(negedge aclk);
        rq_write[port] = wr;
        if (port == 0) begin rq_addr0 = addr; rq_wdata0 = data; end
        else begin rq_addr1 = addr; rq_wdata1 = data; end
        rq_valid[port] = 1'b1;
        for (int i = 0; i < 50 && !granted; i++) begin
            #1;
            if (rq_ready[port]) begin granted = 1'b1; g_cyc = cyc; end
            @(negedge aclk);
        end
        rq_valid[port] = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (rs_valid[port]) begin
                done = 1'b1; rdata = rs_rdata; err = rs_err; r_cyc = cyc;
            end else begin
                @(negedge aclk);
            end
        end
        vectors++;
        if (!granted || !done) begin
            miscompares++;
            $display("FAIL handshake port%0d: granted=%0b done=%0b, required 1 1", port, granted, done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        vectors++;
        if ({rq_ready, rs_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rs_err} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_valids: got %b required 0", {rq_ready, rs_valid, m_awvalid, m_wvalid,
                     m_bready, m_arvalid, m_rready, rs_err});
        end
        vectors++;
        if ({m_awaddr, m_araddr, m_wdata, rs_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rdata=%h required 0",
                     m_awaddr, m_araddr, m_wdata, rs_rdata);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_round_robin();
        int            order[$];
        logic [1:0]    last;
        int            n_done, p0_done, mr0;
        bit            p0_second;
        logic [DW-1:0] rd0;
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        mr0 = multi_rdy_n; n_done = 0; p0_done = 0; p0_second = 1'b0; rd0 = '0;
        @(negedge aclk);
        rq_write = 2'b11; rq_addr0 = 5'h00; rq_wdata0 = 32'h1; rq_addr1 = 5'h04; rq_wdata1 = 32'h2;
        rq_valid = 2'b11;
        for (int i = 0; i < 300 && n_done < 3; i++) begin
            #1;
            last = rq_ready;
            if (last != 2'b00) order.push_back(last[1] ? 1 : 0);
            if (rs_valid != 2'b00) n_done++;
            if (rs_valid[0]) begin
                p0_done++;
                if (p0_done == 2) rd0 = rs_rdata;
            end
            @(negedge aclk);
            if (last[0]) begin
                if (!p0_second) begin p0_second = 1'b1; rq_write[0] = 1'b0; rq_addr0 = 5'h00; end
                else rq_valid[0] = 1'b0;
            end
            if (last[1]) rq_valid[1] = 1'b0;
        end
        rq_valid = 2'b00;
        vectors++;
        if (order.size() != 3) begin
            miscompares++;
            $display("FAIL rr_grant_count: got %0d required 3", order.size());
        end else begin
            vectors++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
                miscompares++;
                $display("FAIL rr_order: got %0d,%0d,%0d required 0,1,0", order[0], order[1], order[2]);
            end
        end
        vectors++;
        if (rd0 !== 32'h1) begin
            miscompares++;
            $display("FAIL rr_readback0: got %h required 00000001", rd0);
        end
        vectors++;
        if (multi_rdy_n != mr0) begin
            miscompares++;
            $display("FAIL rr_onehot_ready: got %0d double grants required 0", multi_rdy_n - mr0);
        end
        do_request(1, 1'b0, 5'h04, '0, g, d, rd, e, gc, rc);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL rr_readback1: got %h required 00000002", rd);
        end
    endtask

    task automatic test_port0_write();
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        int aw0, w0, b0, r1;
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; r1 = rs1_n;
        do_request(0, 1'b1, 5'h00, 32'hDEADBEEF, g, d, rd, e, gc, rc);
        #1;
        vectors++;
        if ({aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0} !== {32'd1, 32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL p0w_handshakes: aw=%0d w=%0d b=%0d required 1 1 1",
                     aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
        end
        vectors++;
        if (slave_regs[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL p0w_reg1: got %h required deadbeef", slave_regs[1]);
        end
        vectors++;
        if (rc != b_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL p0w_latency: rs_valid cycle %0d required %0d", rc, b_hs_cyc + 1);
        end
        vectors++;
        if (rs1_n != r1) begin
            miscompares++;
            $display("FAIL p0w_no_rs1: got %0d pulses required 0", rs1_n - r1);
        end
    endtask

    task automatic test_port1_write_read();
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        int r0;
        r0 = rs0_n;
        do_request(1, 1'b1, 5'h04, 32'h12345678, g, d, rd, e, gc, rc);
        do_request(1, 1'b0, 5'h04, '0, g, d, rd, e, gc, rc);
        vectors++;
        if (rd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL p1_readback: got %h required 12345678", rd);
        end
        #1;
        vectors++;
        if (rs0_n != r0) begin
            miscompares++;
            $display("FAIL p1_no_rs0: got %0d pulses required 0", rs0_n - r0);
        end
    endtask

    task automatic test_aw_delay();
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        int b0, ao0;
        b0 = b_hs_n; ao0 = aw_only_n;
        aw_delay = 3;
        do_request(0, 1'b1, 5'h10, 32'hCAFEF00D, g, d, rd, e, gc, rc);
        aw_delay = 0;
        #1;
        vectors++;
        if (aw_hs_cyc != w_hs_cyc + 3) begin
            miscompares++;
            $display("FAIL awdly_order: aw at %0d w at %0d required aw = w+3", aw_hs_cyc, w_hs_cyc);
        end
        vectors++;
        if (aw_only_n - ao0 != 3) begin
            miscompares++;
            $display("FAIL awdly_w_dropped: got %0d aw-only cycles required 3", aw_only_n - ao0);
        end
        vectors++;
        if (b_hs_n - b0 != 1) begin
            miscompares++;
            $display("FAIL awdly_single_b: got %0d required 1", b_hs_n - b0);
        end
        vectors++;
        if (slave_regs[5] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL awdly_data: got %h required cafef00d", slave_regs[5]);
        end
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        r_never = 1'b1;
        do_request(0, 1'b0, 5'h0C, '0, g, d, rd, e, gc, rc);
        r_never = 1'b0;
        vectors++;
        if (e !== 1'b1 || rd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL to_err: err=%b rdata=%h required 1 12345678", e, rd);
        end
        vectors++;
        if (rc - gc != TO + 1) begin
            miscompares++;
            $display("FAIL to_latency: got %0d cycles required %0d", rc - gc, TO + 1);
        end
        do_request(1, 1'b0, 5'h04, '0, g, d, rd, e, gc, rc);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL to_recover: err=%b rdata=%h required 0 12345678", e, rd);
        end
    endtask
`endif

    task automatic test_reset_mid_txn();
        bit g, d; logic [DW-1:0] rd; logic e; int gc, rc;
        bit granted, in_wresp;
        int r0, r1, b0;
        granted = 1'b0; in_wresp = 1'b0;
        @(negedge aclk);
        rq_write[0] = 1'b1; rq_addr0 = 5'h18; rq_wdata0 = 32'h0BADCAFE; rq_valid[0] = 1'b1;
        for (int i = 0; i < 20 && !granted; i++) begin
            #1;
            if (rq_ready[0]) granted = 1'b1;
            @(negedge aclk);
        end
        rq_valid[0] = 1'b0;
        for (int i = 0; i < 20 && !in_wresp; i++) begin
            #1;
            if (dbg_state == WRESP) in_wresp = 1'b1;
            else @(negedge aclk);
        end
        vectors++;
        if (!in_wresp) begin
            miscompares++;
            $display("FAIL rst_reach_wresp: state %0d required %0d", dbg_state, WRESP);
        end
        r0 = rs0_n; r1 = rs1_n; b0 = b_hs_n;
        areset = 1'b1;
        @(negedge aclk);
        #1;
        vectors++;
        if ({rq_ready, rs_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rs_err} !== 10'b0 ||
            {m_awaddr, m_wdata, rs_rdata} !== '0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL rst_outputs: bready=%b awaddr=%h wdata=%h state=%0d required all 0 / IDLE",
                     m_bready, m_awaddr, m_wdata, dbg_state);
        end
        areset = 1'b0;
        repeat (6) @(negedge aclk);
        #1;
        vectors++;
        if (rs0_n != r0 || rs1_n != r1 || b_hs_n != b0) begin
            miscompares++;
            $display("FAIL rst_no_rs: rs0=%0d rs1=%0d b=%0d required 0 0 0",
                     rs0_n - r0, rs1_n - r1, b_hs_n - b0);
        end
        do_request(0, 1'b1, 5'h18, 32'h0BADCAFE, g, d, rd, e, gc, rc);
        #1;
        vectors++;
        if (slave_regs[7] !== 32'h0BADCAFE) begin
            miscompares++;
            $display("FAIL rst_next_write: got %h required 0badcafe", slave_regs[7]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_port0_write();
        test_port1_write_read();
        test_aw_delay();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
